// File: rtl/mempipe_ld_resp_if.sv
// Shared load-pipe types and the LDQ <-> mem-pipe request/broadcast interface.
// The package is kept here so the interface and the responder see one definition.
package mempipe_ld_resp_pkg;
  localparam int VADDR_W = 32;
  localparam int ID_W    = 3;

  typedef logic [VADDR_W-1:0] t_vaddr;

  typedef enum logic [1:0] {
    MEM_LOAD  = 2'd0,
    MEM_STORE = 2'd1,
    MEM_FILL  = 2'd2,
    MEM_SNOOP = 2'd3
  } t_mempipe_arb_type;

  typedef struct packed {
    t_mempipe_arb_type arb_type;
    logic [ID_W-1:0]   id;
    t_vaddr            addr;
  } t_mempipe_arb;

  typedef struct packed {
    logic complete;
    logic recycle;
  } t_mempipe_action;
endpackage

interface mempipe_ld_resp_if #(parameter int NUM_REQ = 8);
  import mempipe_ld_resp_pkg::*;

  logic [NUM_REQ-1:0]               req_mm0;
  t_mempipe_arb [NUM_REQ-1:0]       req_pkt_mm0;
  logic                             ext_block_mm0;
  logic                             flush;
  logic [NUM_REQ-1:0]               gnt_mm0;
  logic                             dc_lkp_valid_mm1;
  t_vaddr                           dc_lkp_addr_mm1;
  logic                             dc_hit_mm3;
  logic                             pipe_valid_mm5;
  t_mempipe_arb                     pipe_req_pkt_mm5;
  t_mempipe_action                  pipe_action_mm5;

  // master = load queue / dcache side, slave = the mem-pipe responder
  modport master (
    output req_mm0, req_pkt_mm0, ext_block_mm0, flush, dc_hit_mm3,
    input  gnt_mm0, dc_lkp_valid_mm1, dc_lkp_addr_mm1,
           pipe_valid_mm5, pipe_req_pkt_mm5, pipe_action_mm5
  );

  modport slave (
    input  req_mm0, req_pkt_mm0, ext_block_mm0, flush, dc_hit_mm3,
    output gnt_mm0, dc_lkp_valid_mm1, dc_lkp_addr_mm1,
           pipe_valid_mm5, pipe_req_pkt_mm5, pipe_action_mm5
  );
endinterface

// File: rtl/mempipe_ld_resp.sv
// Mem-pipe responder: round-robin grant of LDQ requests at mm0, dcache lookup at mm1,
// hit captured at mm3, complete/recycle broadcast at mm5, saturating perf counters.
module mempipe_ld_resp
  import mempipe_ld_resp_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  mempipe_ld_resp_if.slave bus,
  output logic [CNT_W-1:0] perf_complete_cnt,
  output logic [CNT_W-1:0] perf_recycle_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;

  logic [5:1]         v;
  t_mempipe_arb       pkt [1:5];
  logic               hit_mm4;
  logic               hit_mm5;

  t_mempipe_arb       pkt_out;
  t_mempipe_action    action;

  // Round-robin search starting at rr_ptr; held off during reset, ext block and flush.
  always_comb begin : arb
    logic [PTR_W-1:0] idx;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    if (!reset && !bus.ext_block_mm0 && !bus.flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
        if (!gnt_any && bus.req_mm0[idx]) begin
          gnt_any      = 1'b1;
          gnt[idx]     = 1'b1;
          gnt_idx      = idx;
        end
      end
    end
  end

  assign bus.gnt_mm0 = gnt;

  // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr  <= '0;
      v       <= '0;
      hit_mm4 <= 1'b0;
      hit_mm5 <= 1'b0;
      for (int k = 1; k <= 5; k++) pkt[k] <= '0;
    end else begin
      if (gnt_any) rr_ptr <= PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
      v[1]   <= gnt_any & ~bus.flush;
      pkt[1] <= bus.req_pkt_mm0[gnt_idx];
      for (int k = 2; k <= 5; k++) begin
        v[k]   <= v[k-1] & ~bus.flush;
        pkt[k] <= pkt[k-1];
      end
      hit_mm4 <= bus.dc_hit_mm3;
      hit_mm5 <= hit_mm4;
    end
  end

  assign bus.dc_lkp_valid_mm1 = v[1];
  assign bus.dc_lkp_addr_mm1  = pkt[1].addr;

  // The mm5 broadcast is already committed, so a same-cycle flush does not suppress it.
  always_comb begin
    pkt_out          = pkt[5];
    pkt_out.arb_type = MEM_LOAD;
    action.complete  = v[5] & hit_mm5;
    action.recycle   = v[5] & ~hit_mm5;
  end

  assign bus.pipe_valid_mm5   = v[5];
  assign bus.pipe_req_pkt_mm5 = pkt_out;
  assign bus.pipe_action_mm5  = action;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_complete_cnt <= '0;
      perf_recycle_cnt  <= '0;
    end else begin
      if (action.complete && perf_complete_cnt != {CNT_W{1'b1}})
        perf_complete_cnt <= perf_complete_cnt + 1'b1;
      if (action.recycle && perf_recycle_cnt != {CNT_W{1'b1}})
        perf_recycle_cnt <= perf_recycle_cnt + 1'b1;
    end
  end

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  a_gnt_subset  : assert property (@(posedge clk) disable iff (reset)
                                   (gnt & ~bus.req_mm0) == '0);
  a_gnt_is_load : assert property (@(posedge clk) disable iff (reset)
                                   gnt_any |-> bus.req_pkt_mm0[gnt_idx].arb_type == MEM_LOAD);

endmodule

// File: tb/tb_mempipe_ld_resp.sv
// Scoreboard bench for mempipe_ld_resp: stimulus pushes granted loads, a negedge monitor
// pops them when due and checks lookup, mm5 broadcast and perf counters.
module tb_mempipe_ld_resp;
  import mempipe_ld_resp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mempipe_ld_resp_if #(.NUM_REQ(8)) bus ();
  mempipe_ld_resp_if #(.NUM_REQ(8)) bus2 ();

  logic [15:0] perf_comp, perf_rec;
  logic [1:0]  sat_comp, sat_rec;

  mempipe_ld_resp #(.NUM_REQ(8), .CNT_W(16)) u_dut (
    .clk(clk), .reset(rst), .bus(bus.slave),
    .perf_complete_cnt(perf_comp), .perf_recycle_cnt(perf_rec)
  );

  // Narrow-counter copy sees identical stimulus to exercise saturation.
  assign bus2.req_mm0       = bus.req_mm0;
  assign bus2.req_pkt_mm0   = bus.req_pkt_mm0;
  assign bus2.ext_block_mm0 = bus.ext_block_mm0;
  assign bus2.flush         = bus.flush;
  assign bus2.dc_hit_mm3    = bus.dc_hit_mm3;

  mempipe_ld_resp #(.NUM_REQ(8), .CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(rst), .bus(bus2.slave),
    .perf_complete_cnt(sat_comp), .perf_recycle_cnt(sat_rec)
  );

  typedef struct {
    int          t;
    int          id;
    logic [31:0] addr;
  } exp_t;

  exp_t        q[$];
  bit          hit_hist   [0:8191];
  bit          flush_hist [0:8191];
  logic [31:0] cur_addr   [0:7];
  int          cyc = 0;
  int          m_ptr = 0;
  int          m_comp = 0;
  int          m_rec = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  last_gnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arbiter: first requesting entry at or after ptr, wrapping.
  function automatic int rr_pick(input logic [7:0] req, input int ptr);
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (ptr + k) % 8;
      if (req[j[2:0]]) return j;
    end
    return -1;
  endfunction

  task automatic drive_pkts();
    for (int i = 0; i < 8; i++) begin
      cur_addr[i] = $urandom();
      bus.req_pkt_mm0[i].arb_type = MEM_LOAD;
      bus.req_pkt_mm0[i].id       = 3'(i);
      bus.req_pkt_mm0[i].addr     = cur_addr[i];
    end
  endtask

  task automatic step(input logic [7:0] req, input bit blk, input bit fl, input bit hit);
    int         g;
    logic [7:0] exp_g;
    @(posedge clk);
    #1;
    bus.req_mm0       = req;
    bus.ext_block_mm0 = blk;
    bus.flush         = fl;
    bus.dc_hit_mm3    = hit;
    drive_pkts();
    hit_hist[cyc]   = hit;
    flush_hist[cyc] = fl;
    #1;
    g     = (blk || fl) ? -1 : rr_pick(req, m_ptr);
    exp_g = (g < 0) ? 8'h00 : 8'(1 << g);
    last_gnt = bus.gnt_mm0;
    check("gnt_mm0", 64'(last_gnt), 64'(exp_g));
    if (g >= 0) begin
      m_ptr = (g + 1) % 8;
      q.push_back('{t: cyc, id: g, addr: cur_addr[g]});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},        64'(bus.gnt_mm0), 64'h0);
    check({tag, "_pipe_valid"}, 64'(bus.pipe_valid_mm5), 64'h0);
    check({tag, "_action"},     64'(bus.pipe_action_mm5), 64'h0);
    check({tag, "_lkp_valid"},  64'(bus.dc_lkp_valid_mm1), 64'h0);
    check({tag, "_perf_comp"},  64'(perf_comp), 64'h0);
    check({tag, "_perf_rec"},   64'(perf_rec), 64'h0);
    check({tag, "_sat_comp"},   64'(sat_comp), 64'h0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear without a clock edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    q.delete();
    m_ptr = 0; m_comp = 0; m_rec = 0;
    bus.req_mm0 = '0; bus.ext_block_mm0 = 1'b0; bus.flush = 1'b0; bus.dc_hit_mm3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      bit   ev, eh, lv;
      logic [31:0] la;
      int   sc, sr;
      ev = 1'b0; eh = 1'b0; lv = 1'b0; la = '0;
      foreach (q[i]) if (q[i].t == cyc - 1) begin lv = 1'b1; la = q[i].addr; end
      check("dc_lkp_valid", 64'(bus.dc_lkp_valid_mm1), 64'(lv));
      if (lv) check("dc_lkp_addr", 64'(bus.dc_lkp_addr_mm1), 64'(la));
      if (q.size() > 0 && q[0].t + 5 == cyc) begin
        e  = q.pop_front();
        ev = 1'b1;
        for (int k = 1; k <= 4; k++) if (flush_hist[e.t + k]) ev = 1'b0;
        eh = hit_hist[e.t + 3];
      end
      check("pipe_valid_mm5", 64'(bus.pipe_valid_mm5), 64'(ev));
      check("pipe_action_mm5", 64'(bus.pipe_action_mm5),
            ev ? 64'({eh, ~eh}) : 64'h0);
      if (ev) begin
        check("pkt_id",   64'(bus.pipe_req_pkt_mm5.id), 64'(e.id));
        check("pkt_addr", 64'(bus.pipe_req_pkt_mm5.addr), 64'(e.addr));
        check("pkt_type", 64'(bus.pipe_req_pkt_mm5.arb_type), 64'(MEM_LOAD));
      end
      sc = (m_comp > 3) ? 3 : m_comp;
      sr = (m_rec > 3) ? 3 : m_rec;
      check("perf_complete_cnt", 64'(perf_comp), 64'(m_comp));
      check("perf_recycle_cnt",  64'(perf_rec),  64'(m_rec));
      check("sat_complete_cnt",  64'(sat_comp),  64'(sc));
      check("sat_recycle_cnt",   64'(sat_rec),   64'(sr));
      if (ev) begin
        if (eh) m_comp++;
        else    m_rec++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bus.req_mm0       = 8'hFF;
    bus.ext_block_mm0 = 1'b0;
    bus.flush         = 1'b0;
    bus.dc_hit_mm3    = 1'b0;
    drive_pkts();
    #2;
    check_reset_outputs("reset");
    bus.req_mm0 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Round-robin between entries 0 and 7 from rr_ptr 0.
    step(8'h81, 0, 0, 1); check("rr_0", 64'(last_gnt), 64'h01);
    step(8'h81, 0, 0, 1); check("rr_1", 64'(last_gnt), 64'h80);
    step(8'h81, 0, 0, 1); check("rr_2", 64'(last_gnt), 64'h01);
    step(8'h81, 0, 0, 1); check("rr_3", 64'(last_gnt), 64'h80);

    // Single request with a hit three cycles later.
    step(8'h04, 0, 0, 1); check("single_gnt", 64'(last_gnt), 64'h04);
    repeat (6) step(8'h00, 0, 0, 1);

    // Miss -> recycle.
    step(8'h01, 0, 0, 0);
    repeat (6) step(8'h00, 0, 0, 0);

    // External block suppresses the grant and leaves the pointer alone.
    step(8'hFF, 1, 0, 1); check("block_gnt", 64'(last_gnt), 64'h00);
    step(8'hFF, 0, 0, 1); check("after_block_gnt", 64'(last_gnt), 64'h02);

    // Grants then a flush: everything in flight is killed.
    repeat (3) step(8'hFF, 0, 0, 1);
    step(8'hFF, 0, 1, 1); check("flush_gnt", 64'(last_gnt), 64'h00);
    repeat (6) step(8'h00, 0, 0, 1);

    repeat (1500) step(8'($urandom()), ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0));

    async_reset();

    repeat (300) step(8'($urandom()), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0));
    repeat (8) step(8'h00, 0, 0, 0);

    check("drain_queue_empty", 64'(q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
